alu_mdu_controller: RTL and testbench

ALU_MDU_CONTROLLER -- requirements
Module: alu_mdu_controller

---
 rtl/alu_mdu_controller.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_alu_mdu_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_controller.sv
// ---------------------------------------------------------------------------
// alu_mdu_controller
//
// EX-stage control block for a MIPS-style integer pipeline.  It decodes the
// instruction fields into an ALU operation code, flags undecodable encodings,
// and owns the HI/LO register pair together with an iterative multiply/divide
// unit (one bit per cycle, DATA_W cycles per operation).
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   valid_in     instruction in EX is valid
//   opcode       instruction bits [31:26]
//   funct        instruction bits [5:0]
//   rs_val       rs operand
//   rt_val       rt operand
//   flush        synchronous abort of an in-flight multiply/divide
//   alu_control  ALU operation code (combinational)
//   illegal_op   valid instruction with an undecodable opcode/funct
//   stall        hold request: MDU instruction while the MDU is busy
//   mdu_rdata    HI for MFHI, LO for MFLO, zero otherwise
//   mdu_busy     registered, high while a multiply/divide is running
//   mdu_done     registered, one-cycle pulse after HI/LO written by MDU op
// ---------------------------------------------------------------------------
module alu_mdu_controller #(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  output logic [ALUC_W-1:0] alu_control,
  output logic              illegal_op,
  output logic              stall,
  output logic [DATA_W-1:0] mdu_rdata,
  output logic              mdu_busy,
  output logic              mdu_done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // Absolute value for signed operations; the most negative value maps to
  // its unsigned magnitude 2^(DATA_W-1), which still fits in DATA_W bits.
  function automatic logic [DATA_W-1:0] magnitude(
    input logic signed [DATA_W-1:0] v,
    input logic                     is_signed
  );
    if (is_signed && v[DATA_W-1]) magnitude = -v;
    else                          magnitude = v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg_w(
    input logic [DATA_W-1:0] v,
    input logic              neg
  );
    cond_neg_w = neg ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg_2w(
    input logic [2*DATA_W-1:0] v,
    input logic                neg
  );
    cond_neg_2w = neg ? -v : v;
  endfunction

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient}
  logic [2*DATA_W-1:0] acc;
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W-1:0]   rs_hold;
  logic                neg_q;
  logic                neg_r;
  logic                div_zero;

  logic                      legal;
  logic [3:0]                alu_code;
  logic                      is_special;
  logic                      mdu_instr;
  logic                      f_mfhi, f_mflo, f_mthi, f_mtlo;
  logic                      f_mul, f_div;
  logic                      op_signed;
  logic signed [DATA_W-1:0]  rs_s, rt_s;
  logic [DATA_W-1:0]         mag_rs, mag_rt;
  logic                      last;

  logic [DATA_W:0]           mul_sum;
  logic [2*DATA_W-1:0]       mul_next;
  logic [2*DATA_W-1:0]       mul_res;
  logic [DATA_W:0]           div_shift;
  logic [DATA_W:0]           div_diff;
  logic                      div_ge;
  logic [2*DATA_W-1:0]       div_next;
  logic [DATA_W-1:0]         div_q;
  logic [DATA_W-1:0]         div_r;

  // ALU decode
  always_comb begin
    alu_code = ALU_ADD;
    legal    = 1'b1;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: alu_code = ALU_ADD;
          6'h22, 6'h23: alu_code = ALU_SUB;
          6'h24:        alu_code = ALU_AND;
          6'h25:        alu_code = ALU_OR;
          6'h26:        alu_code = ALU_XOR;
          6'h27:        alu_code = ALU_NOR;
          6'h2A:        alu_code = ALU_SLT;
          6'h2B:        alu_code = ALU_SLTU;
          6'h00:        alu_code = ALU_SLL;
          6'h02:        alu_code = ALU_SRL;
          6'h03:        alu_code = ALU_SRA;
          6'h10, 6'h11, 6'h12, 6'h13,
          6'h18, 6'h19, 6'h1A, 6'h1B: alu_code = ALU_ADD;
          default:      legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: alu_code = ALU_ADD;
      6'h0C:        alu_code = ALU_AND;
      6'h0D:        alu_code = ALU_OR;
      6'h0E:        alu_code = ALU_XOR;
      6'h0A:        alu_code = ALU_SLT;
      6'h0B:        alu_code = ALU_SLTU;
      6'h0F:        alu_code = ALU_LUI;
      6'h23, 6'h2B: alu_code = ALU_ADD;
      6'h04, 6'h05: alu_code = ALU_SUB;
      default:      legal = 1'b0;
    endcase
  end

  assign alu_control = ALUC_W'(alu_code);
  assign illegal_op  = valid_in & ~legal;

  // MDU instruction classification
  assign is_special = (opcode == 6'h00);
  assign f_mfhi     = valid_in && is_special && (funct == 6'h10);
  assign f_mthi     = valid_in && is_special && (funct == 6'h11);
  assign f_mflo     = valid_in && is_special && (funct == 6'h12);
  assign f_mtlo     = valid_in && is_special && (funct == 6'h13);
  assign f_mul      = valid_in && is_special && ((funct == 6'h18) || (funct == 6'h19));
  assign f_div      = valid_in && is_special && ((funct == 6'h1A) || (funct == 6'h1B));
  assign mdu_instr  = f_mfhi | f_mthi | f_mflo | f_mtlo | f_mul | f_div;

  assign stall      = mdu_instr && (state != S_IDLE);
  assign mdu_rdata  = f_mfhi ? hi : (f_mflo ? lo : '0);

  // MULT/DIV are the signed variants (even funct), MULTU/DIVU unsigned
  assign op_signed  = ~funct[0];
  assign rs_s       = rs_val;
  assign rt_s       = rt_val;
  assign mag_rs     = magnitude(rs_s, op_signed);
  assign mag_rt     = magnitude(rt_s, op_signed);

  assign last       = (cnt == CNT_W'(DATA_W - 1));

  // One shift-add multiply step: add multiplicand into the upper half when
  // the current multiplier bit is set, then shift the whole word right.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[DATA_W-1:1]};
    mul_res  = cond_neg_2w(mul_next, neg_q);
  end

  // One restoring-divide step: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits.  The shifted value is
  // always below twice the divisor, so the difference fits in DATA_W bits.
  always_comb begin
    div_shift = acc[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = (div_shift >= {1'b0, opnd});
    if (div_ge) div_next = {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};
    else        div_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    div_q = cond_neg_w(div_next[DATA_W-1:0], neg_q);
    div_r = cond_neg_w(div_next[2*DATA_W-1:DATA_W], neg_r);
  end

  // MDU sequencer and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      opnd     <= '0;
      rs_hold  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      mdu_busy <= 1'b0;
      mdu_done <= 1'b0;
    end else begin
      mdu_done <= 1'b0;
      if (flush) begin
        // abort wins over any start, write or completion this cycle
        state    <= S_IDLE;
        cnt      <= '0;
        mdu_busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (f_mul) begin
              state    <= S_MUL;
              cnt      <= '0;
              acc      <= {{DATA_W{1'b0}}, mag_rt};
              opnd     <= mag_rs;
              rs_hold  <= rs_val;
              neg_q    <= op_signed & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
              neg_r    <= 1'b0;
              div_zero <= 1'b0;
              mdu_busy <= 1'b1;
            end else if (f_div) begin
              state    <= S_DIV;
              cnt      <= '0;
              acc      <= {{DATA_W{1'b0}}, mag_rs};
              opnd     <= mag_rt;
              rs_hold  <= rs_val;
              neg_q    <= op_signed & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
              neg_r    <= op_signed & rs_val[DATA_W-1];
              div_zero <= (rt_val == '0);
              mdu_busy <= 1'b1;
            end else if (f_mthi) begin
              hi <= rs_val;
            end else if (f_mtlo) begin
              lo <= rs_val;
            end
          end
          S_MUL: begin
            acc <= mul_next;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              hi       <= mul_res[2*DATA_W-1:DATA_W];
              lo       <= mul_res[DATA_W-1:0];
              state    <= S_IDLE;
              mdu_busy <= 1'b0;
              mdu_done <= 1'b1;
            end
          end
          S_DIV: begin
            acc <= div_next;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              // divide by zero reports all-ones quotient and the dividend
              hi       <= div_zero ? rs_hold : div_r;
              lo       <= div_zero ? '1      : div_q;
              state    <= S_IDLE;
              mdu_busy <= 1'b0;
              mdu_done <= 1'b1;
            end
          end
          default: begin
            state    <= S_IDLE;
            mdu_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_controller.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu_controller
//
// Self-checking bench for alu_mdu_controller (DATA_W=32).  Expected HI/LO
// results come from a behavioural arithmetic model and are queued when an
// MDU operation is issued, then popped and compared when mdu_done fires.
// ---------------------------------------------------------------------------
module tb_alu_mdu_controller;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic          flush;
  logic [AW-1:0] alu_control;
  logic          illegal_op;
  logic          stall;
  logic [DW-1:0] mdu_rdata;
  logic          mdu_busy;
  logic          mdu_done;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  alu_mdu_controller #(.DATA_W(DW), .ALUC_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .opcode      (opcode),
    .funct       (funct),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .flush       (flush),
    .alu_control (alu_control),
    .illegal_op  (illegal_op),
    .stall       (stall),
    .mdu_rdata   (mdu_rdata),
    .mdu_busy    (mdu_busy),
    .mdu_done    (mdu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural reference: {HI, LO}
  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] a32, b32, q, r;
    logic [63:0] res;
    a32 = a;
    b32 = b;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    res = '0;
    case (fn)
      6'h18: res = sa * sb;
      6'h19: res = {32'h0, a} * {32'h0, b};
      6'h1A: begin
        if (b == 32'h0)                               res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h0, 32'h80000000};
        else begin
          q = a32 / b32;
          r = a32 % b32;
          res = {r, q};
        end
      end
      6'h1B: begin
        if (b == 32'h0) res = {a, 32'hFFFFFFFF};
        else            res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0;
    opcode   = 6'h00;
    funct    = 6'h00;
    flush    = 1'b0;
  endtask

  task automatic dec_chk(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [3:0] exp_alu, input logic exp_ill);
    valid_in = 1'b1;
    opcode   = op;
    funct    = fn;
    #1;
    chk({tag, "_alu"}, alu_control, exp_alu);
    chk({tag, "_ill"}, illegal_op, exp_ill);
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    valid_in = 1'b1;
    opcode   = 6'h00;
    funct    = 6'h10;
    #1;
    h = mdu_rdata;
    funct = 6'h12;
    #1;
    l = mdu_rdata;
    valid_in = 1'b0;
  endtask

  task automatic start_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    valid_in = 1'b1;
    opcode   = 6'h00;
    funct    = fn;
    rs_val   = a;
    rt_val   = b;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic watch_no_done(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (mdu_done) seen = 1'b1;
    end
    chk(tag, seen, 1'b0);
  endtask

  // Wait for completion (bounded), pop the expected result and compare.
  task automatic wait_compare(input string tag);
    int cyc;
    int it;
    logic [31:0] h, l;
    logic [63:0] exp;
    cyc = 1;
    it  = 0;
    while (!mdu_done && it < 100) begin
      @(posedge clk); #1;
      it++;
      if (mdu_busy) cyc++;
    end
    chk({tag, "_done"}, mdu_done, 1'b1);
    chk({tag, "_lat"}, cyc, 32);
    read_hilo(h, l);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
    chk({tag, "_hilo"}, {h, l}, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, mdu_done, 1'b0);
  endtask

  task automatic run_mdu(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b);
    exp_q.push_back(model(fn, a, b));
    start_op(fn, a, b);
    #1;
    chk({tag, "_busy"}, mdu_busy, 1'b1);
    valid_in = 1'b1;
    opcode   = 6'h00;
    funct    = 6'h10;
    #1;
    chk({tag, "_stall_mfhi"}, stall, 1'b1);
    funct = 6'h20;
    #1;
    chk({tag, "_stall_add"}, stall, 1'b0);
    valid_in = 1'b0;
    wait_compare(tag);
  endtask

  initial begin
    logic [31:0] h, l;
    logic [5:0]  fns [4];
    fns[0] = 6'h18; fns[1] = 6'h19; fns[2] = 6'h1A; fns[3] = 6'h1B;

    idle_inputs();
    rs_val = '0;
    rt_val = '0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_busy", mdu_busy, 1'b0);
    chk("rst_done", mdu_done, 1'b0);
    read_hilo(h, l);
    chk("rst_hilo", {h, l}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // decode
    dec_chk("sltu",  6'h00, 6'h2B, 4'd6,  1'b0);
    dec_chk("lui",   6'h0F, 6'h00, 4'd11, 1'b0);
    dec_chk("op3f",  6'h3F, 6'h00, 4'd0,  1'b1);
    dec_chk("subu",  6'h00, 6'h23, 4'd1,  1'b0);
    dec_chk("sra",   6'h00, 6'h03, 4'd10, 1'b0);
    dec_chk("nor",   6'h00, 6'h27, 4'd4,  1'b0);
    dec_chk("ori",   6'h0D, 6'h00, 4'd3,  1'b0);
    dec_chk("bne",   6'h05, 6'h00, 4'd1,  1'b0);
    dec_chk("divu",  6'h00, 6'h1B, 4'd0,  1'b0);
    dec_chk("fn3f",  6'h00, 6'h3F, 4'd0,  1'b1);
    valid_in = 1'b0;
    opcode   = 6'h3F;
    #1;
    chk("ill_novalid", illegal_op, 1'b0);
    idle_inputs();

    // MTLO then MFLO on the next cycle
    @(posedge clk); #1;
    valid_in = 1'b1; opcode = 6'h00; funct = 6'h13; rs_val = 32'h1234;
    @(posedge clk); #1;
    funct = 6'h12;
    #1;
    chk("mflo_fwd", mdu_rdata, 32'h1234);
    chk("mflo_stall", stall, 1'b0);
    idle_inputs();

    // multiply / divide
    run_mdu("mult_m3x7",  6'h18, 32'hFFFFFFFD, 32'd7);
    run_mdu("divu_100_7", 6'h1B, 32'd100, 32'd7);
    run_mdu("div_m7_2",   6'h1A, 32'hFFFFFFF9, 32'd2);
    run_mdu("multu_big",  6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i == 2) ? $urandom_range(1, 1000) : $urandom;
      run_mdu($sformatf("rnd%0d", i), fns[$urandom_range(0, 3)], ra, rb);
    end
    run_mdu("div_by0",    6'h1A, 32'd5, 32'd0);
    run_mdu("div_minm1",  6'h1A, 32'h80000000, 32'hFFFFFFFF);

    // asynchronous reset in the middle of a multiply
    start_op(6'h18, 32'h12345678, 32'd9);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", mdu_busy, 1'b0);
    read_hilo(h, l);
    chk("rstmid_hilo", {h, l}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch_no_done("rstmid_nodone", 40);

    // start accepted on the first edge after reset release
    @(posedge clk); #1;
    rst_n    = 1'b0;
    valid_in = 1'b1; opcode = 6'h00; funct = 6'h19;
    rs_val   = 32'd1000; rt_val = 32'd3000;
    exp_q.push_back(model(6'h19, 32'd1000, 32'd3000));
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("first_busy", mdu_busy, 1'b1);
    wait_compare("first");

    // flush in the middle of a multiply keeps prior HI/LO
    @(posedge clk); #1;
    valid_in = 1'b1; opcode = 6'h00; funct = 6'h11; rs_val = 32'hABCD0001;
    @(posedge clk); #1;
    funct = 6'h13; rs_val = 32'h00001234;
    @(posedge clk); #1;
    valid_in = 1'b0;
    start_op(6'h18, 32'd7, 32'd9);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", mdu_busy, 1'b0);
    watch_no_done("flush_nodone", 40);
    read_hilo(h, l);
    chk("flush_hilo", {h, l}, {32'hABCD0001, 32'h00001234});

    // flush beats a same-cycle start
    @(posedge clk); #1;
    valid_in = 1'b1; opcode = 6'h00; funct = 6'h1A;
    rs_val = 32'd50; rt_val = 32'd5; flush = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    chk("flush_start_busy", mdu_busy, 1'b0);

    run_mdu("after_flush", 6'h1B, 32'hDEADBEEF, 32'd77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
